// File: rtl/t_ff_bank_arbiter.sv
// rtl/t_ff_bank_arbiter.sv - round-robin arbiter sequencing one shared bank of T flip-flops
module t_ff_bank_arbiter #(
    parameter int NREQ        = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     mask,
    output logic [NREQ-1:0]           ack,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   last_grant,
    output logic [WIDTH-1:0]          q
);

    localparam int LW = $clog2(NREQ);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TOGGLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t            state;
    logic [LW-1:0]     ptr;
    logic [LW-1:0]     gnt;
    logic [WIDTH-1:0]  mask_reg;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  t;

    logic [WIDTH-1:0]  slice [NREQ];
    logic              found;
    logic [LW-1:0]     sel;
    logic [LW-1:0]     idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = mask[i*WIDTH +: WIDTH];
    end

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= LW'(NREQ - 1);
            gnt      <= '0;
            mask_reg <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= sel;
                        ptr      <= sel;
                        mask_reg <= slice[sel];
                        state    <= TOGGLE;
                    end
                end
                TOGGLE: begin
                    cnt   <= CW'(HOLD_CYCLES - 1);
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign t = (state == TOGGLE) ? mask_reg : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q ^ t;
        end
    end

    // ack is decoded from the state register so reset clears it immediately.
    assign ack        = (state == TOGGLE) ? (NREQ'(1) << gnt) : '0;
    assign busy       = (state != IDLE);
    assign last_grant = gnt;

endmodule

// File: tb/tb_t_ff_bank_arbiter.sv
// tb/tb_t_ff_bank_arbiter.sv - directed self-checking bench for t_ff_bank_arbiter
module tb_t_ff_bank_arbiter;

    localparam int NREQ        = 4;
    localparam int WIDTH       = 8;
    localparam int HOLD_CYCLES = 3;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] mask;
    logic [NREQ-1:0]       ack;
    logic                  busy;
    logic [1:0]            last_grant;
    logic [WIDTH-1:0]      q;

    int errors = 0;
    int checks = 0;

    t_ff_bank_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .mask(mask),
        .ack(ack),
        .busy(busy),
        .last_grant(last_grant),
        .q(q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mask(input int r, input logic [WIDTH-1:0] m);
        mask[r*WIDTH +: WIDTH] = m;
    endtask

    // Called in IDLE with req already driven; covers one full transaction.
    task automatic wait_grant(input int r, input logic [WIDTH-1:0] exp_q);
        logic [NREQ-1:0] one;
        one = '0;
        one[r] = 1'b1;
        step();
        check("ack_pulse", 32'(ack), 32'(one));
        check("busy_toggle", 32'(busy), 32'd1);
        check("last_grant", 32'(last_grant), 32'(r));
        step();
        check("ack_clear", 32'(ack), 32'd0);
        check("q_after", 32'(q), 32'(exp_q));
        req[r] = 1'b0;
        step();
        check("busy_hold2", 32'(busy), 32'd1);
        step();
        check("busy_hold3", 32'(busy), 32'd1);
        step();
        check("busy_idle", 32'(busy), 32'd0);
        check("ack_idle", 32'(ack), 32'd0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        mask  = '0;

        // 1: asynchronous reset mid-cycle, then quiet idle
        #3 reset = 1'b1;
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_last_grant", 32'(last_grant), 32'd0);
        #3 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_quiet", {21'd0, busy, ack, q}, 32'd0);
        end

        // 2: single requester, repeated toggle cancels
        set_mask(2, 8'hA5);
        req[2] = 1'b1;
        wait_grant(2, 8'hA5);
        req[2] = 1'b1;
        wait_grant(2, 8'h00);

        // 3: all requesters at once from a fresh pointer
        pulse_reset();
        set_mask(0, 8'h01);
        set_mask(1, 8'h02);
        set_mask(2, 8'h04);
        set_mask(3, 8'h08);
        req = 4'b1111;
        wait_grant(0, 8'h01);
        wait_grant(1, 8'h03);
        wait_grant(2, 8'h07);
        wait_grant(3, 8'h0F);

        // 4: after granting 2, requester 3 outranks 1
        set_mask(2, 8'h00);
        req[2] = 1'b1;
        wait_grant(2, 8'h0F);
        req = 4'b1010;
        wait_grant(3, 8'h07);
        wait_grant(1, 8'h05);

        // 5: reset during HOLD restores pointer
        set_mask(0, 8'hFF);
        req[0] = 1'b1;
        step();
        check("t5_ack", 32'(ack), 32'b0001);
        step();
        check("t5_q", 32'(q), 32'hFA);
        req[0] = 1'b0;
        step();
        check("t5_busy_hold", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_q", 32'(q), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ack", 32'(ack), 32'd0);
        #2 reset = 1'b0;
        req = 4'b1001;
        wait_grant(0, 8'hFF);
        req = '0;

        // 6: zero mask, mask change during TOGGLE has no effect
        set_mask(1, 8'h00);
        req[1] = 1'b1;
        step();
        check("t6_ack", 32'(ack), 32'b0010);
        set_mask(1, 8'hFF);
        step();
        check("t6_q", 32'(q), 32'hFF);
        check("t6_ack_clear", 32'(ack), 32'd0);
        req[1] = 1'b0;
        step();
        check("t6_busy2", 32'(busy), 32'd1);
        step();
        check("t6_busy3", 32'(busy), 32'd1);
        step();
        check("t6_busy_idle", 32'(busy), 32'd0);
        check("t6_q_final", 32'(q), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
